// File: rtl/maze_pkg.sv
// Shared definitions for the maze walker: grid geometry, move direction
// encodings, result codes and controller state encoding.
package maze_pkg;

  localparam int unsigned GRID_SIZE = 8;
  localparam int unsigned COORD_W   = 3;
  localparam logic [COORD_W-1:0] COORD_MAX = 3'(GRID_SIZE - 1);

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,  // y-1
    DIR_DOWN  = 2'd1,  // y+1
    DIR_LEFT  = 2'd2,  // x-1
    DIR_RIGHT = 2'd3   // x+1
  } dir_e;

  typedef enum logic [1:0] {
    RES_MOVED = 2'd0,
    RES_WALL  = 2'd1,
    RES_EDGE  = 2'd2,
    RES_DONE  = 2'd3
  } res_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

endpackage

// File: rtl/maze_step.sv
// Combinational single-step target calculator.
// Ports:
//   pos_x_i, pos_y_i : current position
//   dir_i            : move direction (dir_e encoding)
//   tgt_x_o, tgt_y_o : neighbouring cell in that direction (only meaningful
//                      when oob_o is low)
//   oob_o            : the step would leave the grid
module maze_step
  import maze_pkg::*;
(
  input  logic [COORD_W-1:0] pos_x_i,
  input  logic [COORD_W-1:0] pos_y_i,
  input  logic [1:0]         dir_i,
  output logic [COORD_W-1:0] tgt_x_o,
  output logic [COORD_W-1:0] tgt_y_o,
  output logic               oob_o
);

  always_comb begin
    tgt_x_o = pos_x_i;
    tgt_y_o = pos_y_i;
    oob_o   = 1'b0;
    case (dir_e'(dir_i))
      DIR_UP: begin
        tgt_y_o = pos_y_i - 3'd1;
        oob_o   = (pos_y_i == '0);
      end
      DIR_DOWN: begin
        tgt_y_o = pos_y_i + 3'd1;
        oob_o   = (pos_y_i == COORD_MAX);
      end
      DIR_LEFT: begin
        tgt_x_o = pos_x_i - 3'd1;
        oob_o   = (pos_x_i == '0);
      end
      DIR_RIGHT: begin
        tgt_x_o = pos_x_i + 3'd1;
        oob_o   = (pos_x_i == COORD_MAX);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/maze_walker.sv
// Maze walker: moves a token around an 8x8 grid whose walls are read one row
// at a time from an external, registered map ROM.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   restart             : synchronous return to the start cell, aborts a move
//   move_valid/move_dir : move request and direction (0 up,1 down,2 left,3 right)
//   move_ready          : a move can be accepted this cycle
//   rom_en/rom_addr     : map ROM read request (row index)
//   rom_data            : map row, one clock after rom_en; bit (7-col), 1 = open
//   pos_x, pos_y        : current position
//   res_valid/res_code  : one-cycle result pulse (MOVED, WALL, EDGE, DONE)
//   at_goal             : position equals the goal cell
module maze_walker
  import maze_pkg::*;
#(
  parameter int unsigned START_X = 0,
  parameter int unsigned START_Y = 0,
  parameter int unsigned GOAL_X  = 7,
  parameter int unsigned GOAL_Y  = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       restart,
  input  logic       move_valid,
  input  logic [1:0] move_dir,
  output logic       move_ready,
  output logic       rom_en,
  output logic [2:0] rom_addr,
  input  logic [8:0] rom_data,
  output logic [2:0] pos_x,
  output logic [2:0] pos_y,
  output logic       res_valid,
  output logic [1:0] res_code,
  output logic       at_goal
);

  localparam logic [COORD_W-1:0] SX = 3'(START_X);
  localparam logic [COORD_W-1:0] SY = 3'(START_Y);
  localparam logic [COORD_W-1:0] GX = 3'(GOAL_X);
  localparam logic [COORD_W-1:0] GY = 3'(GOAL_Y);

  state_e             state_q, state_d;
  logic [COORD_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [COORD_W-1:0] tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
  logic [COORD_W-1:0] rom_addr_q, rom_addr_d;
  logic               res_valid_q, res_valid_d;
  res_e               res_code_q, res_code_d;

  logic [COORD_W-1:0] step_x, step_y;
  logic               step_oob;
  logic [7:0]         map_row;
  logic               unused_rom_msb;

  maze_step u_step (
    .pos_x_i (pos_x_q),
    .pos_y_i (pos_y_q),
    .dir_i   (move_dir),
    .tgt_x_o (step_x),
    .tgt_y_o (step_y),
    .oob_o   (step_oob)
  );

  assign map_row        = rom_data[7:0];
  assign unused_rom_msb = rom_data[8];

  assign at_goal    = (pos_x_q == GX) && (pos_y_q == GY);
  assign move_ready = (state_q == ST_IDLE) && !restart;
  assign rom_en     = (state_q == ST_FETCH);
  assign rom_addr   = rom_addr_q;
  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign res_valid  = res_valid_q;
  assign res_code   = res_code_q;

  always_comb begin
    state_d     = state_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    tgt_x_d     = tgt_x_q;
    tgt_y_d     = tgt_y_q;
    rom_addr_d  = rom_addr_q;
    res_valid_d = 1'b0;
    res_code_d  = res_code_q;

    if (restart) begin
      state_d = ST_IDLE;
      pos_x_d = SX;
      pos_y_d = SY;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (move_valid) begin
            tgt_x_d = step_x;
            tgt_y_d = step_y;
            if (at_goal) begin
              res_valid_d = 1'b1;
              res_code_d  = RES_DONE;
            end else if (step_oob) begin
              res_valid_d = 1'b1;
              res_code_d  = RES_EDGE;
            end else begin
              rom_addr_d = step_y;
              state_d    = ST_FETCH;
            end
          end
        end
        ST_FETCH: state_d = ST_CHECK;
        ST_CHECK: begin
          res_valid_d = 1'b1;
          state_d     = ST_IDLE;
          if (map_row[3'd7 - tgt_x_q]) begin
            pos_x_d    = tgt_x_q;
            pos_y_d    = tgt_y_q;
            res_code_d = RES_MOVED;
          end else begin
            res_code_d = RES_WALL;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pos_x_q     <= SX;
      pos_y_q     <= SY;
      tgt_x_q     <= '0;
      tgt_y_q     <= '0;
      rom_addr_q  <= '0;
      res_valid_q <= 1'b0;
      res_code_q  <= RES_MOVED;
    end else begin
      state_q     <= state_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      tgt_x_q     <= tgt_x_d;
      tgt_y_q     <= tgt_y_d;
      rom_addr_q  <= rom_addr_d;
      res_valid_q <= res_valid_d;
      res_code_q  <= res_code_d;
    end
  end

endmodule

// File: tb/tb_maze_walker.sv
// Self-checking bench for maze_walker: start (4,0), goal (5,0), map
// row0=0F, row1=FC, other rows closed (bit 8 set to show it is ignored).
module tb_maze_walker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       restart = 1'b0;
  logic       move_valid = 1'b0;
  logic [1:0] move_dir = 2'd0;
  logic       move_ready;
  logic       rom_en;
  logic [2:0] rom_addr;
  logic [8:0] rom_data = 9'h000;
  logic [2:0] pos_x, pos_y;
  logic       res_valid;
  logic [1:0] res_code;
  logic       at_goal;

  int errors = 0;
  int checks = 0;
  int rom_reads = 0;

  always #5 clk = ~clk;

  maze_walker #(.START_X(4), .START_Y(0), .GOAL_X(5), .GOAL_Y(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .restart    (restart),
    .move_valid (move_valid),
    .move_dir   (move_dir),
    .move_ready (move_ready),
    .rom_en     (rom_en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .res_valid  (res_valid),
    .res_code   (res_code),
    .at_goal    (at_goal)
  );

  function automatic logic [8:0] map_row(input logic [2:0] r);
    case (r)
      3'd0:    return 9'h00F;
      3'd1:    return 9'h0FC;
      default: return 9'h100;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rom_en) begin
      rom_data  <= map_row(rom_addr);
      rom_reads <= rom_reads + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; restart = 1'b0; move_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_home(input string tag);
    chk({tag, " pos_x"}, pos_x, 4);
    chk({tag, " pos_y"}, pos_y, 0);
    chk({tag, " res_valid"}, res_valid, 0);
    chk({tag, " res_code"}, res_code, 0);
    chk({tag, " rom_en"}, rom_en, 0);
    chk({tag, " rom_addr"}, rom_addr, 0);
    chk({tag, " at_goal"}, at_goal, 0);
  endtask

  // Issue one move at the next negedge, wait (bounded) for its result.
  task automatic do_move(input logic [1:0] d, output logic seen, output int lat,
                         output logic [1:0] code, output int reads);
    int r0;
    @(negedge clk);
    move_valid = 1'b1;
    move_dir   = d;
    r0 = rom_reads;
    chk("move_ready before accept", move_ready, 1);
    @(posedge clk);
    #1 move_valid = 1'b0;
    seen = 1'b0; lat = 0; code = 2'd0;
    for (int n = 1; n <= 10 && !seen; n++) begin
      @(negedge clk);
      if (res_valid) begin
        seen = 1'b1; lat = n; code = res_code;
      end
    end
    reads = rom_reads - r0;
  endtask

  typedef struct {
    logic [1:0] dir;
    logic [1:0] code;
    int         lat;
    int         reads;
    logic [2:0] x;
    logic [2:0] y;
    logic [2:0] addr;
    logic       goal;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic       seen;
    int         lat, reads, r0;
    logic [1:0] code;

    // dir code lat reads x y addr goal
    vecs[0] = '{2'd1, 2'd0, 3, 1, 3'd4, 3'd1, 3'd1, 1'b0}; // down -> MOVED (4,1)
    vecs[1] = '{2'd1, 2'd1, 3, 1, 3'd4, 3'd1, 3'd2, 1'b0}; // down into closed row 2
    vecs[2] = '{2'd0, 2'd0, 3, 1, 3'd4, 3'd0, 3'd0, 1'b0}; // up back to (4,0)
    vecs[3] = '{2'd2, 2'd1, 3, 1, 3'd4, 3'd0, 3'd0, 1'b0}; // left -> WALL
    vecs[4] = '{2'd0, 2'd2, 1, 0, 3'd4, 3'd0, 3'd0, 1'b0}; // up -> EDGE
    vecs[5] = '{2'd3, 2'd0, 3, 1, 3'd5, 3'd0, 3'd0, 1'b1}; // right -> goal
    vecs[6] = '{2'd1, 2'd3, 1, 0, 3'd5, 3'd0, 3'd0, 1'b1}; // at goal -> DONE

    do_reset();
    #1 check_home("reset");
    chk("reset move_ready", move_ready, 1);

    for (int i = 0; i < 7; i++) begin
      do_move(vecs[i].dir, seen, lat, code, reads);
      chk($sformatf("v%0d result seen", i), seen, 1);
      chk($sformatf("v%0d latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d code", i), code, vecs[i].code);
      chk($sformatf("v%0d rom reads", i), reads, vecs[i].reads);
      chk($sformatf("v%0d pos_x", i), pos_x, vecs[i].x);
      chk($sformatf("v%0d pos_y", i), pos_y, vecs[i].y);
      chk($sformatf("v%0d rom_addr", i), rom_addr, vecs[i].addr);
      chk($sformatf("v%0d at_goal", i), at_goal, vecs[i].goal);
      @(negedge clk);
      chk($sformatf("v%0d pulse single", i), res_valid, 0);
    end

    // Back-to-back EDGE at one per cycle.
    do_reset();
    @(negedge clk);
    r0 = rom_reads;
    move_valid = 1'b1; move_dir = 2'd0;
    @(negedge clk);
    chk("b2b first edge valid", res_valid, 1);
    chk("b2b first edge code", res_code, 2);
    chk("b2b ready while result", move_ready, 1);
    @(negedge clk);
    move_valid = 1'b0;
    chk("b2b second edge valid", res_valid, 1);
    chk("b2b second edge code", res_code, 2);
    @(negedge clk);
    chk("b2b no third pulse", res_valid, 0);
    chk("b2b no rom reads", rom_reads - r0, 0);

    // Restart during CHECK of a move right: aborted, no result.
    @(negedge clk);
    move_valid = 1'b1; move_dir = 2'd3;
    @(posedge clk);
    #1 move_valid = 1'b0;
    @(negedge clk);
    chk("abort fetch rom_en", rom_en, 1);
    @(negedge clk);
    restart = 1'b1;
    chk("abort ready low in restart", move_ready, 0);
    @(negedge clk);
    restart = 1'b0;
    #1;
    chk("abort no res_valid", res_valid, 0);
    chk("abort pos_x", pos_x, 4);
    chk("abort pos_y", pos_y, 0);
    chk("abort move_ready", move_ready, 1);
    @(negedge clk);
    chk("abort still no res_valid", res_valid, 0);

    // Restart wins over a simultaneous move.
    r0 = rom_reads;
    restart = 1'b1; move_valid = 1'b1; move_dir = 2'd0;
    @(negedge clk);
    restart = 1'b0; move_valid = 1'b0;
    chk("restart beats move res_valid", res_valid, 0);
    @(negedge clk);
    chk("restart beats move no read", rom_reads - r0, 0);
    chk("restart beats move no late res", res_valid, 0);

    // Asynchronous reset in the FETCH cycle of a move down.
    @(negedge clk);
    move_valid = 1'b1; move_dir = 2'd1;
    @(posedge clk);
    #1 move_valid = 1'b0;
    @(negedge clk);
    chk("rst mid fetch rom_en before", rom_en, 1);
    chk("rst mid fetch rom_addr before", rom_addr, 1);
    rst_n = 1'b0;
    #1 check_home("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    do_move(2'd1, seen, lat, code, reads);
    chk("post reset move seen", seen, 1);
    chk("post reset move latency", lat, 3);
    chk("post reset move code", code, 0);
    chk("post reset pos_y", pos_y, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/maze_walker.md
MAZE_WALKER -- requirements
Module: maze_walker

Interface
REQ-001 Parameter START_X, default 0, start column (0..7).
REQ-002 Parameter START_Y, default 0, start row (0..7).
REQ-003 Parameter GOAL_X, default 7, goal column; GOAL_Y, default 7, goal row.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 restart  input  1  synchronous return to start position.
REQ-007 move_valid  input  1  move request present.
REQ-008 move_dir  input  2  direction: 0 up (y-1), 1 down (y+1), 2 left (x-1), 3 right (x+1).
REQ-009 move_ready  output  1  block can accept a move.
REQ-010 rom_en  output  1  map ROM read enable.
REQ-011 rom_addr  output  3  map row index.
REQ-012 rom_data  input  9  map row, registered by ROM one clock after rom_en; bit 8 ignored; column c is bit (7-c); 1 = open, 0 = wall.
REQ-013 pos_x, pos_y  output  3 each  current position.
REQ-014 res_valid  output  1  one-cycle result pulse.
REQ-015 res_code  output  2  0 MOVED, 1 WALL, 2 EDGE, 3 DONE.
REQ-016 at_goal  output  1  high while pos equals (GOAL_X, GOAL_Y).

Function
REQ-017 States: IDLE, FETCH, CHECK; move_ready SHALL be 1 only in IDLE with restart low.
REQ-018 Accept on move_valid and move_ready at edge E0; the target is computed from pos and move_dir, and target row/column are latched.
REQ-019 If at_goal at E0: no ROM access, res_valid=1 with DONE in the following cycle, stay IDLE.
REQ-020 Else if target leaves 0..7 (x=0 left, x=7 right, y=0 up, y=7 down): no ROM access, res_valid=1 with EDGE in the following cycle, stay IDLE, no wrap-around.
REQ-021 Else go to FETCH: rom_en=1, rom_addr=target row for exactly one cycle; then CHECK.
REQ-022 In CHECK, sample rom_data bit (7-target_x): if 1, update pos to target at E2 with MOVED; if 0, pos unchanged with WALL; res_valid=1 in cycle after E2; return to IDLE.
REQ-023 Latency: in-bounds move result 3 cycles after acceptance edge; EDGE/DONE 1 cycle.
REQ-024 rom_en SHALL be 0 outside FETCH; rom_addr holds last value.
REQ-025 at_goal SHALL be combinational from pos registers.
REQ-026 restart high in any state: pos<=START, state<=IDLE, in-flight move aborted, no res_valid for it; restart wins over simultaneous move_valid (not accepted).
REQ-027 A new move may be accepted in the same cycle res_valid is high (back-to-back EDGE at 1/cycle).

Reset
REQ-028 rst_n low: state IDLE, pos=(START_X,START_Y), res_valid=0, res_code=0, rom_en=0, rom_addr=0, immediately and asynchronously.
REQ-029 Reset mid-FETCH/CHECK discards the move; first accept possible in the first cycle after deassertion.

Structure
REQ-030 Shared package maze_pkg holds: grid size 8, direction encodings, res_code encodings, state encoding.
REQ-031 One combinational sub-module maze_step (pos, dir -> target, out_of_bounds); the ROM is connected at the parent level, not instantiated here.

Verification
Bench ROM model: row0=8'h0F, row1=8'hFC, others 8'h00, 1-cycle registered read; START_X=4, START_Y=0.
REQ-032 Reset, move down (dir 1) -> rom_en pulse with addr 1, 3 cycles later res_valid with MOVED, pos=(4,1).
REQ-033 From (4,0), move left -> WALL, pos stays (4,0), ROM row 0 read.
REQ-034 From (4,0), move up -> EDGE after 1 cycle, rom_en never asserted; two back-to-back up moves -> two EDGE pulses on consecutive cycles.
REQ-035 Restart asserted in CHECK cycle of a move right -> no res_valid, pos=(4,0), move_ready=1 next cycle.
REQ-036 GOAL_X=5, GOAL_Y=0; move right -> MOVED, at_goal=1; further move -> DONE, pos unchanged; rst_n pulse mid-FETCH -> all outputs at reset values.
